lsu_arbiter: RTL and testbench



---
 rtl/lsu_arb_pkg.sv | 20 ++
 rtl/lsu_arbiter_rr_arb2.sv | 20 ++
 rtl/lsu_arbiter.sv | 152 +++++++++++++++
 tb/tb_lsu_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the load-store unit arbiter.
package lsu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCKED   = 2'd1,
        COOLDOWN = 2'd2
    } arb_state_e;

    typedef logic mst_idx_t;

    localparam int RO_ADDR_BIT_HI = 11;
    localparam int RO_ADDR_BIT_LO = 8;

    // Input-peripheral window: stores here are accepted but never performed.
    function automatic logic is_ro_addr(input logic [31:0] addr);
        return addr[RO_ADDR_BIT_HI] & addr[RO_ADDR_BIT_LO];
    endfunction

endpackage

// File: rtl/lsu_arbiter_rr_arb2.sv
// Two-input round-robin picker producing a one-hot grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a losing requester simply sees no grant this cycle.
module rr_arb2
    import lsu_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  mst_idx_t   last_grant_i,
    input  logic       force_m0_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (force_m0_i || last_grant_i == 1'b1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares the load-store unit between core (m0) and debug loader (m1) with lockable bursts.
// Latency: grant in the request cycle; rvalid/rdata/err registered one cycle later.
// Backpressure: no queueing; a requester holds req and payload until it sees gnt.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    input  logic        m1_lock_i,
    output logic        sten_o,
    output logic [3:0]  byte_num_o,
    output logic [31:0] addr_o,
    output logic [31:0] st_data_o,
    input  logic [31:0] ld_data_i
);

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    arb_state_e  state_q, state_d;
    mst_idx_t    last_grant_q, last_grant_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        sel_we;
    logic        ro_hit;

    // Core is masked out for the whole lock; COOLDOWN hands it first pick.
    assign req = {m1_req_i, m0_req_i & (state_q != LOCKED)};

    rr_arb2 u_rr_arb2 (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .force_m0_i   (state_q == COOLDOWN),
        .gnt_o        (gnt)
    );

    always_comb begin
        sel_we     = 1'b0;
        byte_num_o = '0;
        addr_o     = '0;
        st_data_o  = '0;
        if (gnt[0]) begin
            sel_we     = m0_we_i;
            byte_num_o = m0_be_i;
            addr_o     = m0_addr_i;
            st_data_o  = m0_wdata_i;
        end else if (gnt[1]) begin
            sel_we     = m1_we_i;
            byte_num_o = m1_be_i;
            addr_o     = m1_addr_i;
            st_data_o  = m1_wdata_i;
        end
    end

    assign ro_hit = is_ro_addr(addr_o);
    assign sten_o = sel_we & ~ro_hit;

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = last_grant_q;
        if (gnt[0]) begin
            last_grant_d = 1'b0;
        end else if (gnt[1]) begin
            last_grant_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (gnt[1] && m1_lock_i) begin
                    state_d    = LOCKED;
                    lock_cnt_d = 8'd1;
                end
            end
            LOCKED: begin
                // Release beats expiry when both land in the same cycle.
                if (!m1_lock_i) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == MAX_LOCK_C) begin
                    state_d    = COOLDOWN;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q != 8'hFF) begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        rvalid_d   = gnt;
        err_d      = gnt & {2{sel_we & ro_hit}};
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        if (gnt[0]) m0_rdata_d = sel_we ? 32'd0 : ld_data_i;
        if (gnt[1]) m1_rdata_d = sel_we ? 32'd0 : ld_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            lock_cnt_q   <= '0;
            rvalid_q     <= '0;
            err_q        <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            rvalid_q     <= rvalid_d;
            err_q        <= err_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign m0_gnt_o    = gnt[0];
    assign m1_gnt_o    = gnt[1];
    assign m0_rvalid_o = rvalid_q[0];
    assign m1_rvalid_o = rvalid_q[1];
    assign m0_err_o    = err_q[0];
    assign m1_err_o    = err_q[1];
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed plus randomized bench for lsu_arbiter against a cycle-level behavioural model.
module tb_lsu_arbiter;

    localparam int TB_MAX_LOCK = 4;
    localparam int MD_IDLE = 0;
    localparam int MD_LOCK = 1;
    localparam int MD_COOL = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i, m1_lock_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        sten_o;
    logic [3:0]  byte_num_o;
    logic [31:0] addr_o, st_data_o, ld_data_i;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    int          md_mode;
    int          md_lk;
    int          md_last;
    bit          e_rv0, e_rv1, e_err0, e_err1;
    logic [31:0] e_rd0, e_rd1;
    bit          g0, g1;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign ld_data_i = mem_word(addr_o);

    lsu_arbiter #(.MAX_LOCK(TB_MAX_LOCK)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .m1_lock_i(m1_lock_i),
        .sten_o(sten_o), .byte_num_o(byte_num_o), .addr_o(addr_o), .st_data_o(st_data_o),
        .ld_data_i(ld_data_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md_mode = MD_IDLE; md_lk = 0; md_last = 1;
        e_rv0 = 0; e_rv1 = 0; e_err0 = 0; e_err1 = 0;
        e_rd0 = '0; e_rd1 = '0;
    endtask

    task automatic idle_inputs();
        m0_req_i = 0; m0_we_i = 0; m0_be_i = '0; m0_addr_i = '0; m0_wdata_i = '0;
        m1_req_i = 0; m1_we_i = 0; m1_be_i = '0; m1_addr_i = '0; m1_wdata_i = '0;
        m1_lock_i = 0;
    endtask

    task automatic set_m0(input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        m0_req_i = 1; m0_we_i = we; m0_be_i = be; m0_addr_i = a; m0_wdata_i = d;
    endtask

    task automatic set_m1(input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        m1_req_i = 1; m1_we_i = we; m1_be_i = be; m1_addr_i = a; m1_wdata_i = d;
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Called shortly after inputs settle; checks the cycle and advances the model.
    task automatic cycle();
        logic [31:0] ea, ew;
        logic [3:0]  eb;
        bit          ewe, ro;
        #1;
        check("m0_rvalid", m0_rvalid_o, e_rv0);
        check("m1_rvalid", m1_rvalid_o, e_rv1);
        check("m0_err", m0_err_o, e_err0);
        check("m1_err", m1_err_o, e_err1);
        check("m0_rdata", m0_rdata_o, e_rd0);
        check("m1_rdata", m1_rdata_o, e_rd1);

        g0 = 0; g1 = 0;
        if (md_mode == MD_LOCK) begin
            g1 = m1_req_i;
        end else if (md_mode == MD_COOL) begin
            g0 = m0_req_i;
            g1 = m1_req_i && !m0_req_i;
        end else if (m0_req_i && m1_req_i) begin
            g0 = (md_last == 1);
            g1 = !g0;
        end else begin
            g0 = m0_req_i;
            g1 = m1_req_i;
        end

        ea = g0 ? m0_addr_i : (g1 ? m1_addr_i : 32'd0);
        ew = g0 ? m0_wdata_i : (g1 ? m1_wdata_i : 32'd0);
        eb = g0 ? m0_be_i : (g1 ? m1_be_i : 4'd0);
        ewe = (g0 && m0_we_i) || (g1 && m1_we_i);
        ro = ea[11] && ea[8];

        check("m0_gnt", m0_gnt_o, g0);
        check("m1_gnt", m1_gnt_o, g1);
        check("sten", sten_o, ewe && !ro);
        check("addr", addr_o, ea);
        check("byte_num", byte_num_o, eb);
        check("st_data", st_data_o, ew);

        e_rv0 = g0; e_rv1 = g1;
        e_err0 = g0 && ewe && ro;
        e_err1 = g1 && ewe && ro;
        if (g0) e_rd0 = m0_we_i ? 32'd0 : mem_word(ea);
        if (g1) e_rd1 = m1_we_i ? 32'd0 : mem_word(ea);
        if (g0) md_last = 0;
        if (g1) md_last = 1;

        case (md_mode)
            MD_IDLE: if (g1 && m1_lock_i) begin md_mode = MD_LOCK; md_lk = 1; end
            MD_LOCK: begin
                if (!m1_lock_i) md_mode = MD_IDLE;
                else if (md_lk == TB_MAX_LOCK) md_mode = MD_COOL;
                else md_lk++;
            end
            default: md_mode = MD_IDLE;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit pend0, pend1;
        idle_inputs();
        model_reset();

        // reset state
        repeat (2) @(posedge clk_i);
        tick(); #1;
        check("rst_m0_gnt", m0_gnt_o, 0);
        check("rst_m1_gnt", m1_gnt_o, 0);
        check("rst_m0_rvalid", m0_rvalid_o, 0);
        check("rst_m1_rvalid", m1_rvalid_o, 0);
        check("rst_m0_rdata", m0_rdata_o, 0);
        check("rst_m1_rdata", m1_rdata_o, 0);
        check("rst_sten", sten_o, 0);
        rst_ni = 1;

        // tie rotation from reset
        for (int i = 0; i < 4; i++) begin
            tick();
            set_m0(1, 4'hF, 32'h0000_0020, 32'h1111_0000 + i);
            set_m1(0, 4'h0, 32'h0000_0040, 32'h0);
            cycle();
            check("tie_m0_gnt", m0_gnt_o, (i % 2) == 0);
            check("tie_sten", sten_o, (i % 2) == 0);
        end
        tick(); idle_inputs(); cycle();

        // single load
        tick(); set_m0(0, 4'h0, 32'h0000_0010, 32'h0); cycle();
        check("load_gnt", m0_gnt_o, 1);
        tick(); idle_inputs(); cycle();
        check("load_rvalid", m0_rvalid_o, 1);
        check("load_rdata", m0_rdata_o, 32'hDEAD_BEEF);
        check("load_err", m0_err_o, 0);

        // byte store from m1
        tick(); set_m1(1, 4'h2, 32'h0000_0004, 32'h0000_AB00); cycle();
        check("bst_be", byte_num_o, 4'h2);
        check("bst_sten", sten_o, 1);
        check("bst_data", st_data_o, 32'h0000_AB00);
        tick(); idle_inputs(); cycle();

        // store to read-only region
        tick(); set_m0(1, 4'hF, 32'h0000_0900, 32'h1234_5678); cycle();
        check("ro_gnt", m0_gnt_o, 1);
        check("ro_sten", sten_o, 0);
        tick(); idle_inputs(); cycle();
        check("ro_rvalid", m0_rvalid_o, 1);
        check("ro_err", m0_err_o, 1);

        // bounded lock
        for (int i = 0; i < 8; i++) begin
            tick();
            set_m0(0, 4'h0, 32'h0000_0080, 32'h0);
            set_m1(0, 4'h0, 32'h0000_00C0, 32'h0);
            m1_lock_i = (i < 6);
            cycle();
            check("lock_m1_gnt", m1_gnt_o, (i < 5) || (i == 6));
            check("lock_m0_gnt", m0_gnt_o, (i == 5) || (i == 7));
        end
        tick(); idle_inputs(); cycle();

        // asynchronous reset drops a pending rvalid immediately
        tick(); set_m1(0, 4'h0, 32'h0000_0044, 32'h0); cycle();
        tick(); idle_inputs(); #1;
        check("arst_pre_rvalid", m1_rvalid_o, 1);
        rst_ni = 0; #1;
        check("arst_rvalid", m1_rvalid_o, 0);
        check("arst_rdata", m1_rdata_o, 0);
        model_reset();
        tick(); rst_ni = 1; cycle();

        // reset across the edge after a granted load
        tick(); set_m0(0, 4'h0, 32'h0000_0010, 32'h0); cycle();
        #1; rst_ni = 0; idle_inputs();
        @(posedge clk_i); #1;
        check("rstg_rvalid", m0_rvalid_o, 0);
        check("rstg_rdata", m0_rdata_o, 0);
        model_reset();
        tick(); rst_ni = 1;
        set_m0(0, 4'h0, 32'h0000_0100, 32'h0);
        set_m1(0, 4'h0, 32'h0000_0200, 32'h0);
        cycle();
        check("rstg_tie_m0", m0_gnt_o, 1);
        tick(); idle_inputs(); cycle();

        // randomized traffic honouring the hold-until-grant rule
        pend0 = 0; pend1 = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (!pend0) begin
                m0_req_i = 0;
                if ($urandom_range(0, 99) < 60) begin
                    set_m0($urandom_range(0, 1), 4'($urandom), $urandom & 32'h0000_0FFC, $urandom);
                    pend0 = 1;
                end
            end
            if (!pend1) begin
                m1_req_i = 0;
                if ($urandom_range(0, 99) < 60) begin
                    set_m1($urandom_range(0, 1), 4'($urandom), $urandom & 32'h0000_0FFC, $urandom);
                    pend1 = 1;
                end
            end
            m1_lock_i = ($urandom_range(0, 99) < 80);
            cycle();
            if (g0) pend0 = 0;
            if (g1) pend1 = 0;
        end
        tick(); idle_inputs(); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
